// File: rtl/mac_seq_if.sv
// mac_seq_if -- bundles the signals between mac_sequencer, its job source and
// the mac datapath instance.
//
// Signals
//   start, len                  job request and pair count (requester -> sequencer)
//   busy                        sequencer is not idle
//   op_a, op_b, op_valid        operand pair stream (requester -> sequencer)
//   op_ready                    sequencer is ready for the next pair
//   mac_opcode, mac_data        sequencer -> mac.opcode / mac.data_in
//   mac_data_out                mac.data_out -> sequencer
//   mac_acc_overflow            mac accumulator overflow bit -> sequencer
//   result, result_ovf          {MSW, LSW} of the accumulator and its overflow flag
//   result_valid, result_ready  result handshake
//
// Modports
//   master  the environment side: job source, result consumer and the mac instance
//   slave   mac_sequencer
interface mac_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                      start;
    logic [LEN_WIDTH-1:0]      len;
    logic                      busy;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic                      op_valid;
    logic                      op_ready;
    logic [3:0]                mac_opcode;
    logic [DATA_WIDTH-1:0]     mac_data;
    logic [DATA_WIDTH-1:0]     mac_data_out;
    logic                      mac_acc_overflow;
    logic [2*DATA_WIDTH-1:0]   result;
    logic                      result_ovf;
    logic                      result_valid;
    logic                      result_ready;

    modport master (
        output start, len, op_a, op_b, op_valid, result_ready,
               mac_data_out, mac_acc_overflow,
        input  busy, op_ready, mac_opcode, mac_data,
               result, result_ovf, result_valid
    );

    modport slave (
        input  start, len, op_a, op_b, op_valid, result_ready,
               mac_data_out, mac_acc_overflow,
        output busy, op_ready, mac_opcode, mac_data,
               result, result_ovf, result_valid
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer -- drives a mac datapath through complete dot-product jobs.
//
// A job is requested with start/len in IDLE. The accumulator is cleared, then
// for each operand pair taken over op_valid/op_ready the sequence
// REGA, REGB, MULT, ACC is issued. At the end the accumulator is read back
// as MSW then LSW and offered as result over result_valid/result_ready.
//
// Ports
//   clk        rising-edge clock
//   a_reset_n  asynchronous active-low reset (shared with the mac instance)
//   bus        mac_seq_if.slave: job request, operand stream, mac opcode/data,
//              mac readback and result handshake
//
// Configuration macro
//   MAC_SEQ_OVF_EN  when defined, result_ovf carries mac_acc_overflow sampled
//                   during the MSW read; otherwise result_ovf is tied to 0.
module mac_sequencer #(
    parameter int         DATA_WIDTH = 8,
    parameter int         LEN_WIDTH  = 4,
    parameter logic [3:0] OPC_IDLE   = 4'hF,
    parameter logic [3:0] MAC_RESET  = 4'h0,
    parameter logic [3:0] MAC_REGA   = 4'h1,
    parameter logic [3:0] MAC_REGB   = 4'h2,
    parameter logic [3:0] MAC_MULT   = 4'h3,
    parameter logic [3:0] MAC_ACC    = 4'h4,
    parameter logic [3:0] MAC_MSW    = 4'h5,
    parameter logic [3:0] MAC_LSW    = 4'h6
) (
    input logic      clk,
    input logic      a_reset_n,
    mac_seq_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_WAIT_OP,
        S_LOAD_A,
        S_LOAD_B,
        S_MULT,
        S_ACC,
        S_RD_MSW,
        S_RD_LSW,
        S_CAP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;

    logic [3:0]              opcode;
    logic [DATA_WIDTH-1:0]   mdata;
    logic                    op_ready;
    logic                    res_valid;

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        opcode    = OPC_IDLE;
        mdata     = '0;
        op_ready  = 1'b0;
        res_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.len;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                opcode  = MAC_RESET;
                // A zero-length job skips straight to readback of the cleared accumulator.
                state_d = (cnt_q != '0) ? S_WAIT_OP : S_RD_MSW;
            end
            S_WAIT_OP: begin
                op_ready = 1'b1;
                if (bus.op_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                opcode  = MAC_REGA;
                mdata   = a_q;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                opcode  = MAC_REGB;
                mdata   = b_q;
                state_d = S_MULT;
            end
            S_MULT: begin
                opcode  = MAC_MULT;
                state_d = S_ACC;
            end
            S_ACC: begin
                opcode  = MAC_ACC;
                cnt_d   = cnt_q - LEN_WIDTH'(1);
                state_d = (cnt_q > LEN_WIDTH'(1)) ? S_WAIT_OP : S_RD_MSW;
            end
            S_RD_MSW: begin
                opcode  = MAC_MSW;
                state_d = S_RD_LSW;
            end
            S_RD_LSW: begin
                // mac_data_out is registered in the mac: it now shows the MSW request.
                opcode  = MAC_LSW;
                res_d[2*DATA_WIDTH-1:DATA_WIDTH] = bus.mac_data_out;
                state_d = S_CAP;
            end
            S_CAP: begin
                res_d[DATA_WIDTH-1:0] = bus.mac_data_out;
                state_d = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (bus.result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MAC_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Sampled while the MSW read is issued, i.e. after the last ACC has landed.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_RD_MSW) begin
            ovf_d = bus.mac_acc_overflow;
        end
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.result_ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf     = bus.mac_acc_overflow;
    assign bus.result_ovf = 1'b0;
`endif

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.op_ready     = op_ready;
    assign bus.mac_opcode   = opcode;
    assign bus.mac_data     = mdata;
    assign bus.result       = res_q;
    assign bus.result_valid = res_valid;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer -- directed bench for mac_sequencer with a behavioural
// mac datapath attached to the opcode/data ports.
module tb_mac_sequencer;

    localparam int         DW        = 8;
    localparam int         LW        = 4;
    localparam logic [3:0] OPC_IDLE  = 4'hF;
    localparam logic [3:0] MAC_RESET = 4'h0;
    localparam logic [3:0] MAC_REGA  = 4'h1;
    localparam logic [3:0] MAC_REGB  = 4'h2;
    localparam logic [3:0] MAC_MULT  = 4'h3;
    localparam logic [3:0] MAC_ACC   = 4'h4;
    localparam logic [3:0] MAC_MSW   = 4'h5;
    localparam logic [3:0] MAC_LSW   = 4'h6;

`ifdef MAC_SEQ_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic a_reset_n;

    always #5 clk = ~clk;

    mac_seq_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    mac_sequencer #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .OPC_IDLE  (OPC_IDLE)
    ) dut (
        .clk      (clk),
        .a_reset_n(a_reset_n),
        .bus      (bus)
    );

    // Behavioural mac: registered data_out, sticky accumulator overflow.
    logic [DW-1:0]   m_a, m_b, m_out;
    logic [2*DW-1:0] m_prod, m_acc;
    logic [2*DW:0]   m_sum;
    logic            m_ovf;

    assign m_sum = {1'b0, m_acc} + {1'b0, m_prod};

    always @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            m_a <= '0; m_b <= '0; m_out <= '0; m_prod <= '0; m_acc <= '0; m_ovf <= 1'b0;
        end else begin
            case (bus.mac_opcode)
                MAC_RESET: begin
                    m_a <= '0; m_b <= '0; m_prod <= '0; m_acc <= '0; m_ovf <= 1'b0;
                end
                MAC_REGA: m_a <= bus.mac_data;
                MAC_REGB: m_b <= bus.mac_data;
                MAC_MULT: m_prod <= {8'd0, m_a} * {8'd0, m_b};
                MAC_ACC: begin
                    m_acc <= m_sum[2*DW-1:0];
                    if (m_sum[2*DW]) m_ovf <= 1'b1;
                end
                MAC_MSW: m_out <= m_acc[2*DW-1:DW];
                MAC_LSW: m_out <= m_acc[DW-1:0];
                default: ;
            endcase
        end
    end

    assign bus.mac_data_out     = m_out;
    assign bus.mac_acc_overflow = m_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] pa [8];
    logic [DW-1:0] pb [8];
    logic [3:0]    opc_log [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"},   bus.busy,         0);
        check_val({tag, "_rdy"},    bus.op_ready,     0);
        check_val({tag, "_opc"},    bus.mac_opcode,   OPC_IDLE);
        check_val({tag, "_data"},   bus.mac_data,     0);
        check_val({tag, "_res"},    bus.result,       0);
        check_val({tag, "_ovf"},    bus.result_ovf,   0);
        check_val({tag, "_rvalid"}, bus.result_valid, 0);
    endtask

    // Runs one job from start to acceptance. exp_edge <= 0 skips the latency check;
    // hold > 0 keeps result_ready low that many cycles and pulses start inside the window.
    task automatic run_job(input int n, input int stall, input int hold,
                           input logic [15:0] exp_res, input logic exp_ovf,
                           input int exp_edge, input string tag);
        int edge_n, pi, wait_cnt, rdy_bad, data_bad, n_core, hold_bad;
        bit hs, done;
        opc_log.delete();
        pi = 0; wait_cnt = 0; rdy_bad = 0; data_bad = 0; n_core = 0; hold_bad = 0;
        done = 1'b0;
        bus.start = 1'b1;
        bus.len   = LW'(n);
        step();                             // edge 0
        bus.start = 1'b0;
        bus.len   = '0;
        edge_n    = 0;
        while (edge_n < 400 && !done) begin
            if (!bus.op_valid && pi < n) begin
                if (wait_cnt >= stall) begin
                    bus.op_valid = 1'b1;
                    bus.op_a     = pa[pi];
                    bus.op_b     = pb[pi];
                end else begin
                    wait_cnt++;
                end
            end
            opc_log.push_back(bus.mac_opcode);
            if (bus.op_ready && (bus.mac_opcode != OPC_IDLE || !bus.busy || bus.result_valid))
                rdy_bad++;
            case (bus.mac_opcode)
                MAC_REGA: if (pi == 0 || bus.mac_data !== pa[pi-1]) data_bad++;
                MAC_REGB: if (pi == 0 || bus.mac_data !== pb[pi-1]) data_bad++;
                default:  if (bus.mac_data !== '0) data_bad++;
            endcase
            if (bus.mac_opcode == MAC_REGA || bus.mac_opcode == MAC_REGB ||
                bus.mac_opcode == MAC_MULT || bus.mac_opcode == MAC_ACC)
                n_core++;
            hs = bus.op_valid && bus.op_ready;
            step();
            edge_n++;
            if (hs) begin
                pi++;
                bus.op_valid = 1'b0;
                bus.op_a     = '0;
                bus.op_b     = '0;
                wait_cnt     = 0;
            end
            done = bus.result_valid;
        end
        check_val({tag, "_done"}, done, 1);
        if (exp_edge > 0) check_val({tag, "_edge"}, edge_n, exp_edge);
        check_val({tag, "_result"},  bus.result,     exp_res);
        check_val({tag, "_ovf"},     bus.result_ovf, exp_ovf);
        check_val({tag, "_busy"},    bus.busy,       1);
        check_val({tag, "_pairs"},   pi,             n);
        check_val({tag, "_coreops"}, n_core,         4 * n);
        check_val({tag, "_rdy_bad"}, rdy_bad,        0);
        check_val({tag, "_data_bad"}, data_bad,      0);
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                bus.start = 1'b1;
                bus.len   = 4'd5;
            end
            step();
            bus.start = 1'b0;
            bus.len   = '0;
            if (bus.result !== exp_res || !bus.result_valid || !bus.busy) hold_bad++;
        end
        if (hold > 0) check_val({tag, "_hold_bad"}, hold_bad, 0);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        check_val({tag, "_idle_busy"},   bus.busy,         0);
        check_val({tag, "_idle_rvalid"}, bus.result_valid, 0);
    endtask

    logic [3:0] exp_trace [9];
    int         wait_n;

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.op_a = '0; bus.op_b = '0;
        bus.op_valid = 1'b0; bus.result_ready = 1'b0;
        a_reset_n = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        a_reset_n = 1'b1;
        step();
        check_idle_outputs("post_reset");

        // Single pair (3,5): 15, valid at edge 9.
        pa[0] = 8'd3; pb[0] = 8'd5;
        run_job(1, 0, 0, 16'd15, 1'b0, 9, "single");
        exp_trace = '{MAC_RESET, OPC_IDLE, MAC_REGA, MAC_REGB, MAC_MULT,
                      MAC_ACC, MAC_MSW, MAC_LSW, OPC_IDLE};
        check_val("single_trace_len", opc_log.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < opc_log.size())
                check_val($sformatf("single_trace%0d", i), opc_log[i], exp_trace[i]);
        end

        // Three pairs with 4 idle cycles before each op_valid: 2+12+30 = 44.
        pa[0] = 8'd1; pb[0] = 8'd2;
        pa[1] = 8'd3; pb[1] = 8'd4;
        pa[2] = 8'd5; pb[2] = 8'd6;
        run_job(3, 4, 0, 16'd44, 1'b0, 0, "multi");

        // Back-to-back pairs with no stall: 5N+4 = 19 for N=3.
        run_job(3, 0, 0, 16'd44, 1'b0, 19, "multi_fast");

        // 2 x 255*255 = 0x1FC02, truncated to 0xFC02 with carry out.
        pa[0] = 8'd255; pb[0] = 8'd255;
        pa[1] = 8'd255; pb[1] = 8'd255;
        run_job(2, 0, 0, 16'hFC02, EXP_OVF, 14, "ovf");

        // Zero length: result 0 at edge 4, no core opcodes.
        run_job(0, 0, 0, 16'd0, 1'b0, 4, "zero");

        // Backpressure: 7*9 + 2*10 = 83, result held 10 cycles, start ignored.
        pa[0] = 8'd7; pb[0] = 8'd9;
        pa[1] = 8'd2; pb[1] = 8'd10;
        run_job(2, 0, 10, 16'h0053, 1'b0, 14, "bp");

        // Reset asserted while MULT is on the bus.
        pa[0] = 8'd9; pb[0] = 8'd9;
        bus.start = 1'b1; bus.len = 4'd2;
        step();
        bus.start = 1'b0; bus.len = '0;
        bus.op_valid = 1'b1; bus.op_a = 8'd9; bus.op_b = 8'd9;
        wait_n = 0;
        while (bus.mac_opcode != MAC_MULT && wait_n < 50) begin
            step();
            wait_n++;
        end
        check_val("midrst_reached_mult", bus.mac_opcode, MAC_MULT);
        a_reset_n = 1'b0;
        bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
        #1;
        check_idle_outputs("midrst");
        step();
        step();
        a_reset_n = 1'b1;
        step();
        check_idle_outputs("midrst_rel");

        // Job after mid-job reset: 9*9 = 81.
        run_job(1, 0, 0, 16'd81, 1'b0, 9, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
